// File: rtl/dial_pkg.sv
// Shared types and helpers for the dial engine.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package dial_pkg;

    // Default rotation-word width; the divider's default dividend width follows it.
    localparam int DEF_DATA_W = 32;
    localparam int DIV_W      = DEF_DATA_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DIV,
        S_UPDATE,
        S_DONE
    } dial_state_t;

    // Unsigned dividend whose quotient by N is the number of zero hits and
    // whose remainder encodes the new position. The rotation is passed
    // sign-extended to 64 bits, so |r| of the most negative word is exact.
    // This works for any rotation width up to 63 bits.
    function automatic logic [64:0] dial_dividend(
        input logic [63:0] r,
        input logic [63:0] pos,
        input logic [63:0] n
    );
        logic [64:0] m;
        m = {1'b0, ~r} + 65'd1;
        if (!r[63]) begin
            return {1'b0, r} + {1'b0, pos};
        end else if (pos == 64'd0) begin
            return m;
        end else begin
            return m + {1'b0, n - pos};
        end
    endfunction

endpackage

// File: rtl/dial_divmod.sv
// Restoring unsigned divider of a DIV_W-bit dividend by the constant DIVISOR.
// Latency: done pulses exactly DIV_W cycles after start; one quotient bit per cycle.
// Backpressure: none; start restarts at once; quot/rem hold until the next start.
module dial_divmod
    import dial_pkg::*;
#(
    parameter int DIV_W   = dial_pkg::DIV_W,
    parameter int DIVISOR = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    output logic             done,
    output logic [DIV_W-1:0] quot,
    output logic [DIV_W-1:0] rem
);

    localparam int CW = $clog2(DIV_W + 1);
    localparam logic [DIV_W:0] DVSR = (DIV_W + 1)'(DIVISOR);

    logic [DIV_W-1:0] acc_q, rem_q;
    logic [DIV_W-1:0] src_acc, src_rem, acc_nxt, rem_nxt;
    logic [DIV_W:0]   trial, diff;
    logic             fits;
    logic [CW-1:0]    cnt_q;
    logic             done_q;
    logic             unused_diff_msb;

    // One restoring step; the first step runs in the start cycle itself so
    // the whole division fits in exactly DIV_W cycles.
    always_comb begin
        src_acc = start ? dividend : acc_q;
        src_rem = start ? '0 : rem_q;
        trial   = {src_rem, src_acc[DIV_W-1]};
        diff    = trial - DVSR;
        fits    = (trial >= DVSR);
        rem_nxt = fits ? diff[DIV_W-1:0] : trial[DIV_W-1:0];
        acc_nxt = {src_acc[DIV_W-2:0], fits};
    end

    // Remainder stays below DIVISOR, so the borrow bit of diff is never needed.
    assign unused_diff_msb = diff[DIV_W];

    // Shift/subtract sequencer; the done pulse coincides with the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (start) begin
            acc_q  <= acc_nxt;
            rem_q  <= rem_nxt;
            cnt_q  <= CW'(DIV_W - 1);
            done_q <= 1'b0;
        end else if (cnt_q != '0) begin
            acc_q  <= acc_nxt;
            rem_q  <= rem_nxt;
            cnt_q  <= cnt_q - CW'(1);
            done_q <= (cnt_q == CW'(1));
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done = done_q;
    assign quot = acc_q;
    assign rem  = rem_q;

endmodule

// File: rtl/dial_engine.sv
// Streams signed rotation words from BRAM and counts zero landings (part1) and zero hits (part2).
// Latency: DATA_W+4 cycles per word plus one cycle into DONE; size 0 completes the cycle after start.
// Backpressure: none; start is ignored while busy, counters saturate and set sticky sat_o.
module dial_engine
    import dial_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 32,
    parameter int DIAL_SIZE = 100,
    parameter int START_POS = 50
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   size,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [DATA_W-1:0]   bram_dout,
    output logic                busy_o,
    output logic                done_o,
    output logic [CNT_W-1:0]    part1_o,
    output logic [CNT_W-1:0]    part2_o,
    output logic                sat_o,
    output logic                bram_en,
    output logic [ADDR_W-1:0]   bram_addr,
    output logic [DATA_W/8-1:0] bram_we
);

    localparam int DW    = DATA_W + 1;
    localparam int SUM_W = ((CNT_W > DW) ? CNT_W : DW) + 1;
    localparam logic [DW-1:0]    N_D     = DW'(DIAL_SIZE);
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    dial_state_t state_q, state_d;

    logic [ADDR_W-1:0] size_q, base_q, idx_q;
    logic [DW-1:0]     pos_q, pos_new;
    logic              neg_q;
    logic [CNT_W-1:0]  part1_q, part2_q, p1_new, p2_new;
    logic              sat_q;
    logic              start_ok, last_word;
    logic              div_start, div_done;
    logic [DW-1:0]     div_dvd, div_q, div_rem;
    logic [63:0]       r_ext;
    logic [64:0]       d_full;
    logic              unused_dvd_hi;
    logic [SUM_W-1:0]  p2_sum;
    logic              p2_clip, p1_hit, p1_clip;

    assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_word = ((idx_q + ADDR_W'(1)) == size_q);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and divider launch.
    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = (size == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH:  state_d = S_WAIT;
            S_WAIT: begin
                div_start = 1'b1;
                state_d   = S_DIV;
            end
            S_DIV: begin
                if (div_done) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: state_d = last_word ? S_DONE : S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    // Dividend from the word arriving in WAIT and the current position.
    always_comb begin
        r_ext   = {{(64 - DATA_W){bram_dout[DATA_W-1]}}, bram_dout};
        d_full  = dial_dividend(r_ext, 64'(pos_q), 64'(DIAL_SIZE));
        div_dvd = d_full[DW-1:0];
    end

    // The dividend never exceeds DW bits for legal dial sizes.
    assign unused_dvd_hi = ^d_full[64:DW];

    // New position and saturating counter updates applied in UPDATE.
    always_comb begin
        if (!neg_q) begin
            pos_new = div_rem;
        end else begin
            pos_new = (div_rem == '0) ? '0 : (N_D - div_rem);
        end
        p2_sum  = SUM_W'(part2_q) + SUM_W'(div_q);
        p2_clip = (p2_sum > CNT_MAX);
        p2_new  = p2_clip ? {CNT_W{1'b1}} : p2_sum[CNT_W-1:0];
        p1_hit  = (pos_new == '0);
        p1_clip = p1_hit && (&part1_q);
        p1_new  = part1_q + CNT_W'(p1_hit && !p1_clip);
    end

    // Run context, position and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_q  <= '0;
            base_q  <= '0;
            idx_q   <= '0;
            pos_q   <= DW'(START_POS);
            neg_q   <= 1'b0;
            part1_q <= '0;
            part2_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        size_q  <= size;
                        base_q  <= base_addr;
                        idx_q   <= '0;
                        pos_q   <= DW'(START_POS);
                        part1_q <= '0;
                        part2_q <= '0;
                        sat_q   <= 1'b0;
                    end
                end
                S_WAIT: neg_q <= bram_dout[DATA_W-1];
                S_UPDATE: begin
                    pos_q   <= pos_new;
                    part1_q <= p1_new;
                    part2_q <= p2_new;
                    sat_q   <= sat_q | p1_clip | p2_clip;
                    idx_q   <= idx_q + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    dial_divmod #(
        .DIV_W   (DW),
        .DIVISOR (DIAL_SIZE)
    ) u_divmod (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (div_dvd),
        .done     (div_done),
        .quot     (div_q),
        .rem      (div_rem)
    );

    assign busy_o    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o    = (state_q == S_DONE);
    assign part1_o   = part1_q;
    assign part2_o   = part2_q;
    assign sat_o     = sat_q;
    assign bram_en   = (state_q == S_FETCH);
    assign bram_addr = base_q + (idx_q << 2);
    assign bram_we   = '0;

endmodule

// File: tb/tb_dial_engine.sv
// Bench for dial_engine: three parameterisations driven in lockstep from one BRAM image.
// Latency: expects DATA_W+4 cycles per word plus one into DONE.
// Backpressure: n/a; checks that start is ignored while busy.
module tb_dial_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] size, base_addr;

    logic [31:0] dout0, dout1, dout2;
    logic        busy0, busy1, busy2, done0, done1, done2;
    logic [31:0] p1_0, p2_0, p1_1, p2_1;
    logic [3:0]  p1_2, p2_2;
    logic        sat0, sat1, sat2, en0, en1, en2;
    logic [31:0] addr0, addr1, addr2;
    logic [3:0]  we0, we1, we2;

    logic [31:0] mem [0:63];
    int          words[$];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    dial_engine u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .size(size), .base_addr(base_addr),
        .bram_dout(dout0), .busy_o(busy0), .done_o(done0), .part1_o(p1_0), .part2_o(p2_0),
        .sat_o(sat0), .bram_en(en0), .bram_addr(addr0), .bram_we(we0));

    dial_engine #(.DIAL_SIZE(10), .START_POS(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .size(size), .base_addr(base_addr),
        .bram_dout(dout1), .busy_o(busy1), .done_o(done1), .part1_o(p1_1), .part2_o(p2_1),
        .sat_o(sat1), .bram_en(en1), .bram_addr(addr1), .bram_we(we1));

    dial_engine #(.CNT_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .size(size), .base_addr(base_addr),
        .bram_dout(dout2), .busy_o(busy2), .done_o(done2), .part1_o(p1_2), .part2_o(p2_2),
        .sat_o(sat2), .bram_en(en2), .bram_addr(addr2), .bram_we(we2));

    // BRAM model with one cycle of read latency per port.
    always @(posedge clk) begin
        if (en0) dout0 <= mem[addr0[7:2]];
        if (en1) dout1 <= mem[addr1[7:2]];
        if (en2) dout2 <= mem[addr2[7:2]];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: walk the dial one rotation at a time, counting zero hits
    // directly from the distance to the next zero in the direction of travel.
    task automatic model(input longint n, input longint sp, input int cw,
                         output longint p1, output longint p2, output bit sat);
        longint pos, r, m, first, t1, t2, maxv;
        pos = sp; t1 = 0; t2 = 0;
        maxv = (longint'(1) << cw) - 1;
        foreach (words[k]) begin
            r = longint'(words[k]);
            if (r >= 0) begin
                t2  += (pos + r) / n;
                pos  = (pos + r) % n;
            end else begin
                m     = -r;
                first = (pos == 0) ? n : pos;
                if (m >= first) t2 += 1 + (m - first) / n;
                pos = (((pos - m) % n) + n) % n;
            end
            if (pos == 0) t1++;
        end
        sat = (t1 > maxv) || (t2 > maxv);
        p1  = (t1 > maxv) ? maxv : t1;
        p2  = (t2 > maxv) ? maxv : t2;
    endtask

    task automatic check_all(input string tag);
        longint e1, e2;
        bit     es;
        model(100, 50, 32, e1, e2, es);
        chk({tag, "_u0_p1"}, 64'(p1_0), e1);
        chk({tag, "_u0_p2"}, 64'(p2_0), e2);
        chk({tag, "_u0_sat"}, 64'(sat0), 64'(es));
        model(10, 0, 32, e1, e2, es);
        chk({tag, "_u1_p1"}, 64'(p1_1), e1);
        chk({tag, "_u1_p2"}, 64'(p2_1), e2);
        chk({tag, "_u1_sat"}, 64'(sat1), 64'(es));
        model(100, 50, 4, e1, e2, es);
        chk({tag, "_u2_p1"}, 64'(p1_2), e1);
        chk({tag, "_u2_p2"}, 64'(p2_2), e2);
        chk({tag, "_u2_sat"}, 64'(sat2), 64'(es));
    endtask

    // Load the word list at base b, start, wait for done and check the run.
    task automatic run_job(input string tag, input logic [31:0] b, input bit poke);
        int n, cyc, nen, limit;
        n = words.size();
        foreach (words[k]) mem[(b >> 2) + k] = words[k];
        size = n; base_addr = b;
        limit = n * 36 + 40;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 1; nen = 0;
        while (!done0 && cyc < limit) begin
            chk({tag, "_busy"}, 64'(busy0), 64'd1);
            if (en0) begin
                chk({tag, "_addr"}, 64'(addr0), 64'(b + 32'(4 * nen)));
                nen++;
            end
            if (poke && cyc == 40) begin
                start = 1'b1; base_addr = 32'h100; size = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk) cyc++;
        end
        size = n; base_addr = b;
        chk({tag, "_latency"}, 64'(cyc), 64'(n * 36 + 1));
        chk({tag, "_reads"}, 64'(nen), 64'(n));
        chk({tag, "_done_all"}, 64'({done0, done1, done2, busy0}), 64'b1110);
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; size = '0; base_addr = '0;
        foreach (mem[k]) mem[k] = '0;
        repeat (3) @(negedge clk);
        chk("rst_state", 64'({busy0, done0, en0, sat0}), 64'd0);
        chk("rst_p1", 64'(p1_0), 64'd0);
        chk("rst_p2", 64'(p2_0), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reference sequence from the first-generation solver.
        words = '{-68, -30, 48, -5, 60, -55, -1, -99, 14, -82, -32};
        run_job("tp1", 32'h0, 1'b0);
        chk("tp1_p1_const", 64'(p1_0), 64'd4);
        chk("tp1_p2_const", 64'(p2_0), 64'd7);

        // Large positive rotation, then restart with counters cleared.
        words = '{1000};
        run_job("big", 32'h0, 1'b0);
        chk("big_p2_const", 64'(p2_0), 64'd10);
        words = '{-50, -100};
        run_job("restart", 32'h0, 1'b0);
        chk("restart_p1_const", 64'(p1_0), 64'd2);
        chk("restart_p2_const", 64'(p2_0), 64'd2);

        // Empty job.
        words = {};
        run_job("size0", 32'h0, 1'b0);
        chk("size0_p2", 64'(p2_0), 64'd0);

        // Start pulse mid-run must be ignored.
        words = '{7, -300, 123};
        run_job("poke", 32'h20, 1'b1);

        // Small dial, and the most negative word.
        words = '{25};
        run_job("n10", 32'h0, 1'b0);
        chk("n10_p2_const", 64'(p2_1), 64'd2);
        chk("n10_p1_const", 64'(p1_1), 64'd0);
        words = '{int'(32'h8000_0000)};
        run_job("minword", 32'h0, 1'b0);
        chk("minword_q_const", 64'(p2_1), 64'd214748364);

        // Narrow counter saturation.
        words = '{2000};
        run_job("sat", 32'h0, 1'b0);
        chk("sat_p2_const", 64'(p2_2), 64'd15);
        chk("sat_flag_const", 64'(sat2), 64'd1);

        // Randomised jobs.
        for (int j = 0; j < 4; j++) begin
            int n;
            n = $urandom_range(1, 8);
            words = {};
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) words.push_back(int'($urandom));
                else words.push_back(int'($urandom_range(0, 600)) - 300);
            end
            run_job($sformatf("rand%0d", j), 32'h0, 1'b0);
        end

        // Asynchronous reset in the middle of the second word's division.
        words = '{1000, 7};
        foreach (words[k]) mem[k] = words[k];
        size = 2; base_addr = 32'h0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (45) @(negedge clk);
        chk("pre_rst_p2", 64'(p2_0), 64'd10);
        chk("pre_rst_busy", 64'(busy0), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 64'(busy0), 64'd0);
        chk("async_rst_p2", 64'(p2_0), 64'd0);
        chk("async_rst_addr", 64'(addr0), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (80) begin
                @(negedge clk);
                if (done0 || busy0) seen++;
            end
            chk("no_done_after_rst", 64'(seen), 64'd0);
        end
        words = '{-50, 5};
        run_job("rebase", 32'h40, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dial_engine.md
Name: dial_engine

Overview:
- Parametrised successor to the fixed 100-position dial solver: generic dial size, start position, data/counter widths and BRAM base address.
- Streams `size` signed rotation words from a 1-cycle-latency BRAM and accumulates two results:
  - part1: landings on position 0.
  - part2: every pass through or landing on position 0.
- Sits behind the AXI-Lite register block and shares the PS-loaded BRAM read port.
- Adds behaviour the first generation lacked: busy/error status, counter saturation, exact large-rotation arithmetic and a restartable done state.

Parameters:
- DATA_W, 32, width of one signed rotation word.
- ADDR_W, 32, BRAM byte-address width.
- CNT_W, 32, width of the part1/part2 counters (saturating).
- DIAL_SIZE, 100, number of dial positions N; legal range 2..2^(DATA_W-2).
- START_POS, 50, position loaded at each start; must be less than DIAL_SIZE.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle start pulse; honoured only when busy_o=0.
- size  in  ADDR_W  number of rotation words; latched on accepted start.
- base_addr  in  ADDR_W  byte address of word 0 (word aligned); latched on accepted start.
- bram_dout  in  DATA_W  read data, valid the cycle after bram_en.
- busy_o  out  1  high from accepted start until done.
- done_o  out  1  high from completion until the next accepted start.
- part1_o  out  CNT_W  landing-on-zero count.
- part2_o  out  CNT_W  zero-hit count (passes plus landings).
- sat_o  out  1  sticky; set when either counter saturates; cleared on start.
- bram_en  out  1  read enable.
- bram_addr  out  ADDR_W  byte address = base_addr + 4*i.
- bram_we  out  DATA_W/8  tied to 0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs and counters go to 0; state goes to IDLE; position register goes to START_POS.
  - Reset in any state aborts the run; no done_o pulse follows.
- States: IDLE, FETCH, WAIT, DIV, UPDATE, DONE.
- IDLE or DONE with start=1:
  - Latch size and base_addr; set pos=START_POS; clear part1, part2 and sat_o; set i=0.
  - Set busy_o=1 and done_o=0.
  - Go to FETCH, or to DONE directly if size=0 (done_o high the next cycle, results 0).
- start while busy_o=1 is ignored.
- FETCH (1 cycle): bram_en=1 with bram_addr=base_addr+4*i; go to WAIT. bram_en is 0 in every other state.
- WAIT (1 cycle): capture r=bram_dout (signed) and form an unsigned dividend d of DATA_W+1 bits:
  - r >= 0: d = pos + r.
  - r < 0, m = |r|: d = m if pos=0, else d = m + (N - pos). m of -2^(DATA_W-1) is exact.
  - Launch the divider and go to DIV.
- DIV: the divider takes exactly DATA_W+1 cycles and yields q = d / N and rem = d mod N.
- UPDATE (1 cycle):
  - New position: r >= 0 gives pos = rem; r < 0 gives pos = (rem = 0) ? 0 : N - rem.
  - part2 += q; part1 += 1 if the new pos = 0. Both saturate at 2^CNT_W-1, setting sat_o.
  - i++. If i = size go to DONE, else go to FETCH.
  - r = 0 leaves pos unchanged, and part1 still counts it if pos = 0.
- Throughput: exactly DATA_W+4 cycles per word.
- DONE: busy_o=0, done_o=1; part1_o, part2_o and sat_o are held until the next accepted start.

Decomposition:
- dial_pkg holds:
  - the state enum type;
  - a function computing the dividend;
  - the constant DIV_W = DATA_W+1.
- Sub-module dial_divmod:
  - restoring unsigned sequential divider, DIV_W-bit dividend by a constant DIAL_SIZE divisor;
  - start/done handshake; done is a 1-cycle pulse exactly DIV_W cycles after start;
  - q and rem stay stable until the next start.

Test Plan:
- Defaults, base_addr=0, size=11, words -68,-30,48,-5,60,-55,-1,-99,14,-82,-32 -> done_o after 11*(36) cycles+1; part1_o=4, part2_o=7, sat_o=0.
- Single word +1000 -> part2_o=10, part1_o=0 (final pos 50). Then restart with words -50,-100 -> part1_o=2, part2_o=2, the counters having been cleared by start.
- size=0 -> done_o one cycle after start, counters 0, bram_en never asserted. A start pulse mid-run is ignored and bram_addr continues its sequence.
- DIAL_SIZE=10, START_POS=0, word +25 -> part2_o=2, part1_o=0; word -2^31 with DATA_W=32 -> q=214748364, no overflow.
- CNT_W=4, word +2000 -> part2_o=15, sat_o=1.
- rst_n low during DIV -> outputs 0 immediately (asynchronously). A following start with base_addr=0x40 gives the first bram_addr=0x40.
